// File: rtl/trdb_reg_bank.sv
`timescale 1ns/1ps
// trdb_reg_bank: configuration/status register bank for the trace debugger.
// Serves per_* requests with a two-state IDLE/RESP handshake, drives the
// tracer control fields and collects overflow/busy/packet-count status.
// Optional feature macro: TRDB_REG_PKT_CNT_EN (implements the PKT_CNT register).
module trdb_reg_bank #(
    parameter int APB_ADDR_WIDTH = 12
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      per_valid_i,
    input  logic                      per_we_i,
    input  logic [APB_ADDR_WIDTH-1:0] per_addr_i,
    input  logic [31:0]               per_wdata_i,
    output logic [31:0]               per_rdata_o,
    output logic                      per_ready_o,
    output logic                      trace_enable_o,
    output logic                      trace_clear_o,
    output logic                      filter_en_o,
    output logic                      filter_inv_o,
    output logic [31:0]               filter_lo_o,
    output logic [31:0]               filter_hi_o,
    input  logic                      overflow_i,
    input  logic                      busy_i,
    input  logic                      pkt_i
);

    localparam logic [31:0] ID_VALUE    = 32'h7D4B_0001;
    localparam logic [2:0]  IDX_CTRL    = 3'd0;
    localparam logic [2:0]  IDX_STATUS  = 3'd1;
    localparam logic [2:0]  IDX_LO      = 3'd2;
    localparam logic [2:0]  IDX_HI      = 3'd3;
    localparam logic [2:0]  IDX_PKT_CNT = 3'd4;
    localparam logic [2:0]  IDX_ID      = 3'd5;

    typedef enum logic {IDLE, RESP} state_t;

    state_t      state;
    logic        hit;
    logic [2:0]  idx;
    logic        accept;
    logic        wr_hit;
    logic        ctrl_wr;
    logic        clear;
    logic        status_w1c;
    logic        overflow;
    logic [31:0] pkt_cnt_view;
    logic [31:0] rdata_next;
    logic        unused_addr;

    // Only word offsets 0x00-0x1C decode; any higher address bit set is a miss.
    assign hit         = (per_addr_i >> 5) == '0;
    assign idx         = per_addr_i[4:2];
    assign unused_addr = ^per_addr_i[1:0];

    assign accept     = (state == IDLE) && per_valid_i;
    assign wr_hit     = accept && per_we_i && hit;
    assign ctrl_wr    = wr_hit && (idx == IDX_CTRL);
    assign clear      = ctrl_wr && per_wdata_i[1];
    assign status_w1c = wr_hit && (idx == IDX_STATUS) && per_wdata_i[0];

`ifdef TRDB_REG_PKT_CNT_EN
    logic [31:0] pkt_cnt;

    // Packet counter: clear beats a software write, which beats an increment; saturates at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pkt_cnt <= '0;
        end else if (clear) begin
            pkt_cnt <= '0;
        end else if (wr_hit && (idx == IDX_PKT_CNT)) begin
            pkt_cnt <= per_wdata_i;
        end else if (pkt_i && trace_enable_o && (pkt_cnt != '1)) begin
            pkt_cnt <= pkt_cnt + 32'd1;
        end
    end

    assign pkt_cnt_view = pkt_cnt;
`else
    logic unused_pkt;

    assign pkt_cnt_view = '0;
    assign unused_pkt   = pkt_i;
`endif

    // Read view of the register map; misses and reserved slots read zero.
    always_comb begin
        rdata_next = '0;
        if (hit) begin
            case (idx)
                IDX_CTRL:    rdata_next = {28'd0, filter_inv_o, filter_en_o, 1'b0, trace_enable_o};
                IDX_STATUS:  rdata_next = {30'd0, busy_i, overflow};
                IDX_LO:      rdata_next = filter_lo_o;
                IDX_HI:      rdata_next = filter_hi_o;
                IDX_PKT_CNT: rdata_next = pkt_cnt_view;
                IDX_ID:      rdata_next = ID_VALUE;
                default:     rdata_next = '0;
            endcase
        end
    end

    // Handshake FSM: accept in IDLE, answer with a single ready pulse in RESP.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            per_ready_o <= 1'b0;
            per_rdata_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    per_ready_o <= 1'b0;
                    if (per_valid_i) begin
                        state       <= RESP;
                        per_ready_o <= 1'b1;
                        if (!per_we_i) begin
                            per_rdata_o <= rdata_next;
                        end
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    per_ready_o <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    per_ready_o <= 1'b0;
                end
            endcase
        end
    end

    // Control fields and filter window; the clear bit only produces a one-cycle pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            trace_enable_o <= 1'b0;
            trace_clear_o  <= 1'b0;
            filter_en_o    <= 1'b0;
            filter_inv_o   <= 1'b0;
            filter_lo_o    <= 32'h0000_0000;
            filter_hi_o    <= 32'hFFFF_FFFF;
        end else begin
            trace_clear_o <= clear;
            if (ctrl_wr) begin
                trace_enable_o <= per_wdata_i[0];
                filter_en_o    <= per_wdata_i[2];
                filter_inv_o   <= per_wdata_i[3];
            end
            if (wr_hit && (idx == IDX_LO)) begin
                filter_lo_o <= per_wdata_i;
            end
            if (wr_hit && (idx == IDX_HI)) begin
                filter_hi_o <= per_wdata_i;
            end
        end
    end

    // Sticky overflow: a new event always wins over W1C or a clear on the same edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow <= 1'b0;
        end else if (overflow_i) begin
            overflow <= 1'b1;
        end else if (status_w1c || clear) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_trdb_reg_bank.sv
`timescale 1ns/1ps
// tb_trdb_reg_bank: directed bench for trdb_reg_bank with a register-map model.
module tb_trdb_reg_bank;

`ifdef TRDB_REG_PKT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam logic [31:0] ID_VALUE = 32'h7D4B_0001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        valid = 1'b0;
    logic        we = 1'b0;
    logic [11:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready;
    logic        trace_enable;
    logic        trace_clear;
    logic        filter_en;
    logic        filter_inv;
    logic [31:0] filter_lo;
    logic [31:0] filter_hi;
    logic        overflow = 1'b0;
    logic        busy = 1'b0;
    logic        pkt = 1'b0;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_on  = 1'b0;

    trdb_reg_bank #(.APB_ADDR_WIDTH(12)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .per_valid_i    (valid),
        .per_we_i       (we),
        .per_addr_i     (addr),
        .per_wdata_i    (wdata),
        .per_rdata_o    (rdata),
        .per_ready_o    (ready),
        .trace_enable_o (trace_enable),
        .trace_clear_o  (trace_clear),
        .filter_en_o    (filter_en),
        .filter_inv_o   (filter_inv),
        .filter_lo_o    (filter_lo),
        .filter_hi_o    (filter_hi),
        .overflow_i     (overflow),
        .busy_i         (busy),
        .pkt_i          (pkt)
    );

    always #5 clk = ~clk;

    // ---------------- model: register words indexed by word offset ----------------
    logic [31:0] m_reg [0:7];
    logic [31:0] m_rdata;
    logic        m_resp;
    logic        m_clear;

    function automatic logic [31:0] wmask(input int i);
        case (i)
            0:       return 32'h0000_000D;
            2, 3:    return 32'hFFFF_FFFF;
            4:       return CNT_EN ? 32'hFFFF_FFFF : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a, input logic b);
        int i;
        i = int'(a[4:2]);
        if (a[11:5] != 0) return 32'h0;
        if (i == 1) return {30'd0, b, m_reg[1][0]};
        if (i == 5) return ID_VALUE;
        return m_reg[i];
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < 8; i++) m_reg[i] = 32'h0;
                m_reg[3] = 32'hFFFF_FFFF;
                m_rdata  = 32'h0;
                m_resp   = 1'b0;
                m_clear  = 1'b0;
            end else begin
                bit acc;
                int i;
                acc     = !m_resp && valid;
                i       = int'(addr[4:2]);
                m_clear = 1'b0;
                if (acc && !we) m_rdata = model_read(addr, busy);
                if (CNT_EN && pkt && m_reg[0][0] && m_reg[4] != 32'hFFFF_FFFF)
                    m_reg[4] = m_reg[4] + 1;
                if (acc && we && addr[11:5] == 0) begin
                    m_reg[i] = (m_reg[i] & ~wmask(i)) | (wdata & wmask(i));
                    if (i == 1 && wdata[0]) m_reg[1] = 32'h0;
                    if (i == 0 && wdata[1]) begin
                        m_clear  = 1'b1;
                        m_reg[4] = 32'h0;
                        m_reg[1] = 32'h0;
                    end
                end
                if (overflow) m_reg[1] = 32'h1;
                m_resp = acc;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    endtask

    // Every falling edge, compare all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("m_ready",  {31'd0, ready},        {31'd0, m_resp});
                chk("m_rdata",  rdata,                 m_rdata);
                chk("m_enable", {31'd0, trace_enable}, {31'd0, m_reg[0][0]});
                chk("m_fen",    {31'd0, filter_en},    {31'd0, m_reg[0][2]});
                chk("m_finv",   {31'd0, filter_inv},   {31'd0, m_reg[0][3]});
                chk("m_clear",  {31'd0, trace_clear},  {31'd0, m_clear});
                chk("m_lo",     filter_lo,             m_reg[2]);
                chk("m_hi",     filter_hi,             m_reg[3]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_total=%0d", n_total);
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xact(input logic w, input logic [11:0] a, input logic [31:0] d,
                        output logic [31:0] rd);
        valid = 1'b1; we = w; addr = a; wdata = d;
        tick();
        valid = 1'b0;
        chk("ready_latency", {31'd0, ready}, 32'd1);
        rd = rdata;
        tick();
        chk("ready_one_cycle", {31'd0, ready}, 32'd0);
    endtask

    task automatic rd_chk(input string nm, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] r;
        xact(1'b0, a, 32'h0, r);
        chk(nm, r, exp);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        logic [31:0] r;
        xact(1'b1, a, d, r);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        chk_on = 1'b1;
        repeat (3) tick();
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_enable", {31'd0, trace_enable}, 32'd0);
        chk("rst_lo", filter_lo, 32'h0);
        chk("rst_hi", filter_hi, 32'hFFFF_FFFF);
        rst_n = 1'b1;
        tick();

        rd_chk("rd_lo", 12'h008, 32'h0000_0000);
        rd_chk("rd_hi", 12'h00C, 32'hFFFF_FFFF);
        rd_chk("rd_id", 12'h014, 32'h7D4B_0001);

        // CTRL write visible during the response cycle
        valid = 1'b1; we = 1'b1; addr = 12'h000; wdata = 32'h5;
        tick();
        valid = 1'b0;
        chk("ctrl_enable_resp", {31'd0, trace_enable}, 32'd1);
        chk("ctrl_fen_resp", {31'd0, filter_en}, 32'd1);
        tick();
        rd_chk("rd_ctrl", 12'h000, 32'h5);

        // Packet counting and saturation
        pkt = 1'b1;
        repeat (3) tick();
        pkt = 1'b0;
        rd_chk("cnt_3", 12'h010, CNT_EN ? 32'd3 : 32'd0);
        wr(12'h010, 32'hFFFF_FFFE);
        pkt = 1'b1;
        repeat (2) tick();
        pkt = 1'b0;
        rd_chk("cnt_sat", 12'h010, CNT_EN ? 32'hFFFF_FFFF : 32'd0);

        // Sticky overflow, busy, W1C racing a new event
        busy = 1'b1;
        overflow = 1'b1;
        tick();
        overflow = 1'b0;
        rd_chk("status_ovf_busy", 12'h004, 32'h3);
        busy = 1'b0;
        valid = 1'b1; we = 1'b1; addr = 12'h004; wdata = 32'h1; overflow = 1'b1;
        tick();
        valid = 1'b0; overflow = 1'b0;
        tick();
        rd_chk("status_set_wins", 12'h004, 32'h1);
        wr(12'h004, 32'h1);
        rd_chk("status_w1c", 12'h004, 32'h0);

        // Clear pulse with a packet on the same edge
        overflow = 1'b1;
        tick();
        overflow = 1'b0;
        valid = 1'b1; we = 1'b1; addr = 12'h000; wdata = 32'h3; pkt = 1'b1;
        tick();
        valid = 1'b0; pkt = 1'b0;
        chk("clear_high", {31'd0, trace_clear}, 32'd1);
        tick();
        chk("clear_low", {31'd0, trace_clear}, 32'd0);
        rd_chk("clear_ctrl", 12'h000, 32'h1);
        rd_chk("clear_cnt", 12'h010, 32'h0);
        rd_chk("clear_ovf", 12'h004, 32'h0);

        // Reserved and out-of-range addresses
        wr(12'h020, 32'h0);
        chk("oob_write_ignored", {31'd0, trace_enable}, 32'd1);
        rd_chk("rd_id_again", 12'h014, ID_VALUE);
        rd_chk("rd_oob", 12'h034, 32'h0);

        // Valid held for three cycles: one pulse, then re-accept
        rd_chk("rd_id_prime", 12'h014, ID_VALUE);
        valid = 1'b1; we = 1'b0; addr = 12'h01C;
        tick();
        chk("hold_ready_1", {31'd0, ready}, 32'd1);
        chk("rd_1c", rdata, 32'h0);
        tick();
        chk("hold_ready_2", {31'd0, ready}, 32'd0);
        tick();
        chk("hold_ready_3", {31'd0, ready}, 32'd1);
        valid = 1'b0;
        tick();
        chk("hold_ready_4", {31'd0, ready}, 32'd0);

        // Reset asserted during the response cycle
        wr(12'h00C, 32'h0000_1234);
        valid = 1'b1; we = 1'b1; addr = 12'h008; wdata = 32'h1234_5678;
        tick();
        valid = 1'b0;
        chk("mid_lo_written", filter_lo, 32'h1234_5678);
        chk("mid_ready", {31'd0, ready}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {31'd0, ready}, 32'd0);
        chk("mid_rst_lo", filter_lo, 32'h0);
        chk("mid_rst_hi", filter_hi, 32'hFFFF_FFFF);
        chk("mid_rst_enable", {31'd0, trace_enable}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", {31'd0, ready}, 32'd0);
        rd_chk("post_rst_hi", 12'h00C, 32'hFFFF_FFFF);

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
